// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle datapath: mul/div opcodes and the
// mul/div FSM states, also decoded by the controller's wait state.
package mc_pkg;

    localparam logic [1:0] MD_OP_MUL  = 2'b00;
    localparam logic [1:0] MD_OP_MULH = 2'b01;
    localparam logic [1:0] MD_OP_DIV  = 2'b10;
    localparam logic [1:0] MD_OP_REM  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIX  = 2'b10,
        MD_DONE = 2'b11
    } mdState_t;

endpackage

// File: rtl/mc_muldiv_unit.sv
// Iterative radix-2 shift-add multiplier and restoring divider, one bit per
// cycle. Both algorithms run on magnitudes and share a single adder.
module mc_muldiv_unit
    import mc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit SIGNED_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic                  signed_op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  div_by_zero
);

    // state | meaning
    // IDLE  | waiting for start; result/div_by_zero hold the last completion
    // RUN   | W shift-add or restoring-divide iterations
    // FIX   | sign fix-up, load result and div_by_zero
    // DONE  | done pulse for one cycle

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;

    function automatic logic [W-1:0] condNeg(input logic [W-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    mdState_t        state;
    logic [CW-1:0]   count;
    logic [1:0]      opR;
    logic            sa, sb;
    logic [W-1:0]    aMag, bMag, aOrig;
    logic [W-1:0]    hi, lo;
    logic            busyR, doneR, dbzR;
    logic [W-1:0]    resultR;

    logic            sgnIn, aNeg, bNeg;
    logic [W-1:0]    aMagIn, bMagIn;

    assign sgnIn  = SIGNED_EN && signed_op;
    assign aNeg   = sgnIn && a[W-1];
    assign bNeg   = sgnIn && b[W-1];
    assign aMagIn = condNeg(a, aNeg);
    assign bMagIn = condNeg(b, bNeg);

    // Multiply: {hi,lo} is the product/multiplier shift pair.
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    logic [W:0]      addA, addB;
    logic            addCin;
    logic [W+1:0]    addSum;
    logic            noBorrow;

    always_comb begin
        addA   = {1'b0, hi};
        addB   = lo[0] ? {1'b0, aMag} : '0;
        addCin = 1'b0;
        if (opR[1]) begin
            addA   = {hi, lo[W-1]};
            addB   = ~{1'b0, bMag};
            addCin = 1'b1;
        end
    end

    assign addSum   = {1'b0, addA} + {1'b0, addB} + {{(W+1){1'b0}}, addCin};
    assign noBorrow = addSum[W+1];

    logic [2*W-1:0]  prodFix;
    logic [W-1:0]    quotFix, remFix;

    assign prodFix = (sa ^ sb) ? -{hi, lo} : {hi, lo};
    assign quotFix = condNeg(lo, sa ^ sb);
    assign remFix  = condNeg(hi, sa);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= MD_IDLE;
            count   <= '0;
            opR     <= MD_OP_MUL;
            sa      <= 1'b0;
            sb      <= 1'b0;
            aMag    <= '0;
            bMag    <= '0;
            aOrig   <= '0;
            hi      <= '0;
            lo      <= '0;
            busyR   <= 1'b0;
            doneR   <= 1'b0;
            dbzR    <= 1'b0;
            resultR <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        opR   <= op;
                        sa    <= aNeg;
                        sb    <= bNeg;
                        aMag  <= aMagIn;
                        bMag  <= bMagIn;
                        aOrig <= a;
                        hi    <= '0;
                        lo    <= op[1] ? aMagIn : bMagIn;
                        count <= '0;
                        busyR <= 1'b1;
                        state <= (op[1] && (b == '0)) ? MD_FIX : MD_RUN;
                    end
                end
                MD_RUN: begin
                    count <= count + CW'(1);
                    if (opR[1]) begin
                        hi <= noBorrow ? addSum[W-1:0] : addA[W-1:0];
                        lo <= {lo[W-2:0], noBorrow};
                    end else begin
                        hi <= addSum[W:1];
                        lo <= {addSum[0], lo[W-1:1]};
                    end
                    if (count == CW'(W-1)) state <= MD_FIX;
                end
                MD_FIX: begin
                    doneR <= 1'b1;
                    state <= MD_DONE;
                    if (opR[1] && (bMag == '0)) begin
                        dbzR    <= 1'b1;
                        resultR <= (opR == MD_OP_DIV) ? '1 : aOrig;
                    end else begin
                        dbzR <= 1'b0;
                        case (opR)
                            MD_OP_MUL:  resultR <= prodFix[W-1:0];
                            MD_OP_MULH: resultR <= prodFix[2*W-1:W];
                            MD_OP_DIV:  resultR <= quotFix;
                            default:    resultR <= remFix;
                        endcase
                    end
                end
                MD_DONE: begin
                    doneR <= 1'b0;
                    busyR <= 1'b0;
                    state <= MD_IDLE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

    assign busy        = busyR;
    assign done        = doneR;
    assign result      = resultR;
    assign div_by_zero = dbzR;

endmodule

// File: doc/mc_muldiv_unit.md
Name: mc_muldiv_unit

Overview:
- Parametrised iterative multiply/divide execution unit for the multicycle datapath. It extends the single-cycle ALU with MUL, MULH, DIV and REM.
- It is a radix-2 shift-add multiplier plus a restoring divider, one bit per cycle, with optional signed operation.
- A start/busy/done handshake lets the controller hold in a wait state until done.
- The result is registered and held until the next accepted start, so it can feed the MemToReg path like ALUOut.

Parameters:
- DATA_WIDTH, 32, operand/result width W (≥4).
- SIGNED_EN, 1. When 1, signed_op is honoured; when 0, signed_op is ignored and all ops are unsigned.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only in IDLE.
- op  input  2  00 MUL (low W of product), 01 MULH (high W), 10 DIV (quotient), 11 REM (remainder).
- signed_op  input  1  two's-complement operands when 1.
- a  input  W  multiplicand / dividend.
- b  input  W  multiplier / divisor.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when the result is valid.
- result  output  W  registered result.
- div_by_zero  output  1  registered flag, valid with done.

Behaviour:
- Reset (rst=0, async): state=IDLE, busy=0, done=0, result=0, div_by_zero=0, count=0, all internal accumulators 0.
- FSM states are IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 at edge k latches op, signed_op, and |a|, |b| (magnitudes if signed, raw otherwise).
  - It latches sign bits sa, sb and clears count.
  - Next state is RUN, or FIX if the op is DIV/REM and b==0.
- RUN:
  - One iteration per edge; count increments.
  - After W iterations (edges k+1..k+W) the state goes to FIX.
- FIX, single edge (k+W+1, or k+1 for the divide-by-zero path):
  - Applies the sign fix-up.
  - Loads result and div_by_zero.
  - Next state is DONE.
- DONE: done=1 for exactly one cycle; next edge goes to IDLE.
- Latency: done is high in the cycle after edge k+W+1, i.e. W+2 cycles after the start edge. Divide by zero takes 2 cycles.
- busy is high from the cycle after edge k through the DONE cycle inclusive.
- start while busy: ignored, no effect on state or operands. The controller must not rely on queuing.
- start in the DONE cycle: ignored; a new start is accepted only from IDLE.
- Multiply:
  - 2W-bit product P via shift-add.
  - Signed: if sa^sb, P = -P, computed on 2W bits.
  - MUL returns P[W-1:0]; MULH returns P[2W-1:W].
- Divide:
  - Restoring, W steps.
  - Quotient negated if sa^sb; remainder negated if sa (sign follows dividend).
- Signed overflow (a = most negative, b = -1): the magnitude path yields quotient = most negative and remainder = 0. This result is required, with no special case and no flag.
- Divide by zero:
  - DIV result = all ones; REM result = a as originally presented.
  - div_by_zero=1.
- div_by_zero is 0 for all other completions.
- result and div_by_zero hold their values until the FIX state of the next operation. They do not clear on return to IDLE.
- Operand inputs need only be stable at the accepting edge.
- Reset asserted mid-operation aborts immediately to reset values; no done is produced.

Decomposition:
- Shared package mc_pkg holds localparams:
  - MD_OP_MUL=2'b00, MD_OP_MULH=2'b01, MD_OP_DIV=2'b10, MD_OP_REM=2'b11.
  - FSM state encodings MD_IDLE/MD_RUN/MD_FIX/MD_DONE.
- The controller includes the same package for its wait-state decode.
- No sub-module is required. Magnitude/negate is a local function; the shift-add and restoring-divide steps share one W+1-bit adder/subtractor inside the module.

Test Plan:
- Unsigned MUL: a=32'hFFFF_FFFF, b=32'h2, op=00 → result 32'hFFFF_FFFE, done exactly 34 cycles after start; op=01 with the same operands → 32'h1.
- Signed MULH/MUL: a=-3, b=7, signed_op=1 → MUL 32'hFFFF_FFEB (-21), MULH 32'hFFFF_FFFF.
- Signed DIV/REM: a=-7, b=2 → DIV 32'hFFFF_FFFD (-3), REM 32'hFFFF_FFFF (-1). Unsigned a=100, b=7 → DIV 14, REM 2.
- Divide by zero: a=32'h1234, b=0, op=10 → result 32'hFFFF_FFFF, div_by_zero=1, done 2 cycles after start. Same with op=11 → result 32'h1234.
- Overflow and ignored start: signed a=32'h8000_0000, b=-1 → DIV 32'h8000_0000, REM 0. A second start pulse with different operands at cycle 5 of the run → no effect on result or latency.
- Reset mid-op: drop rst at cycle 10 of a DIV → busy=0, done=0, result=0 immediately. After release, a new MUL 6*7 → 42 with nominal latency.
